seven_seg_scanner: RTL and testbench

- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display.
- Takes a 16-bit hex value, per-digit enables and decimal points through a load handshake.
- Updates the displayed image only at frame boundaries, so there is no tearing.
- Scans the digits using the shared FreqDivider ClkEnable tick; it sits beside the button/LED logic in the top level and drives an, seg and dp.

---
 rtl/seven_seg_scanner_if.sv | 25 ++
 rtl/seven_seg_scanner.sv | 122 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Load handshake between the value producer and the seven-segment scanner.
// The producer drives an image plus Load; the scanner answers with LoadAck.
interface seven_seg_scanner_if;
    logic [15:0] Value;
    logic [3:0]  DigitEn;
    logic [3:0]  DpIn;
    logic        Load;
    logic        LoadAck;

    modport master (
        output Value,
        output DigitEn,
        output DpIn,
        output Load,
        input  LoadAck
    );

    modport slave (
        input  Value,
        input  DigitEn,
        input  DpIn,
        input  Load,
        output LoadAck
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// New images are staged on Load and swapped in only at frame boundaries.
module seven_seg_scanner #(
    parameter int TICKS_PER_DIGIT = 4,
    parameter int BLANK_TICKS     = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 ClkEnable,
    seven_seg_scanner_if.slave   load_bus,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic                 FrameDone
);

    localparam int CNT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICKS_PER_DIGIT - 1);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  en;
        logic [3:0]  dp;
    } image_t;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    image_t           live;
    image_t           staging;
    image_t           shadow;
    logic             pending;

    logic             last_tick;
    logic             boundary;
    logic             in_blank;
    logic             digit_on;
    logic [3:0]       cur_nib;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            4'hF: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        live.value = load_bus.Value;
        live.en    = load_bus.DigitEn;
        live.dp    = load_bus.DpIn;
        last_tick  = (cnt == LAST_CNT);
        boundary   = ClkEnable && last_tick && (idx == 2'd3);
        in_blank   = (BLANK_TICKS != 0) && (int'(cnt) < BLANK_TICKS);
        digit_on   = shadow.en[idx] && !in_blank;
        cur_nib    = shadow.value[{idx, 2'b00} +: 4];
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, whatever the block order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (ClkEnable) begin
            if (last_tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A Load in the boundary cycle itself bypasses staging straight to shadow.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            staging          <= '0;
            shadow           <= '0;
            pending          <= 1'b0;
            load_bus.LoadAck <= 1'b0;
        end else begin
            load_bus.LoadAck <= 1'b0;
            if (boundary && (load_bus.Load || pending)) begin
                shadow           <= load_bus.Load ? live : staging;
                pending          <= 1'b0;
                load_bus.LoadAck <= 1'b1;
            end else if (load_bus.Load) begin
                staging <= live;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            an        <= 4'b1111;
            seg       <= 7'b1111111;
            dp        <= 1'b1;
            FrameDone <= 1'b0;
        end else begin
            an        <= digit_on ? ~(4'b0001 << idx) : 4'b1111;
            seg       <= hex_to_seg(cur_nib);
            dp        <= ~shadow.dp[idx];
            FrameDone <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: a frame-position reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_seven_seg_scanner;

    localparam int T     = 4;
    localparam int B     = 1;
    localparam int FRAME = 4 * T;

    logic       Clk       = 1'b0;
    logic       Rst       = 1'b1;
    logic       ClkEnable = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       FrameDone;

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .TICKS_PER_DIGIT (T),
        .BLANK_TICKS     (B)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .ClkEnable (ClkEnable),
        .load_bus  (bus),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .FrameDone (FrameDone)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;
    int ce_mode = 1;  // 0 off, 1 every clock, 2 one-in-five, 3 random
    int ce_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_rom [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          m_tick;   // position within the frame, in ticks
    int          m_dig;
    int          m_pos;
    bit          m_bnd;
    bit          m_pend;
    logic [15:0] m_val,  st_val;
    logic [3:0]  m_en,   st_en;
    logic [3:0]  m_dp,   st_dp;
    logic [3:0]  e_an  = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp  = 1'b1;
    logic        e_ack = 1'b0;
    logic        e_fd  = 1'b0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_tick = 0; m_pend = 1'b0;
            m_val = '0; m_en = '0; m_dp = '0;
            st_val = '0; st_en = '0; st_dp = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_fd = 1'b0;
        end else begin
            m_dig = m_tick / T;
            m_pos = m_tick % T;
            e_an  = (m_pos < B || !m_en[m_dig]) ? 4'hF : ~(4'b0001 << m_dig);
            e_seg = seg_rom[m_val[4*m_dig +: 4]];
            e_dp  = ~m_dp[m_dig];
            m_bnd = ClkEnable && (m_tick == FRAME - 1);
            e_fd  = m_bnd;
            e_ack = 1'b0;
            if (m_bnd && bus.Load) begin
                m_val = bus.Value; m_en = bus.DigitEn; m_dp = bus.DpIn;
                m_pend = 1'b0; e_ack = 1'b1;
            end else if (m_bnd && m_pend) begin
                m_val = st_val; m_en = st_en; m_dp = st_dp;
                m_pend = 1'b0; e_ack = 1'b1;
            end else if (bus.Load) begin
                st_val = bus.Value; st_en = bus.DigitEn; st_dp = bus.DpIn;
                m_pend = 1'b1;
            end
            if (ClkEnable) m_tick = (m_tick + 1) % FRAME;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en && !Rst) begin
            check("cmp_an",   32'(an),           32'(e_an));
            check("cmp_seg",  32'(seg),          32'(e_seg));
            check("cmp_dp",   32'(dp),           32'(e_dp));
            check("cmp_ack",  32'(bus.LoadAck),  32'(e_ack));
            check("cmp_fd",   32'(FrameDone),    32'(e_fd));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        forever begin
            @(negedge Clk);
            case (ce_mode)
                0: ClkEnable = 1'b0;
                1: ClkEnable = 1'b1;
                2: begin
                    ce_phase  = (ce_phase + 1) % 5;
                    ClkEnable = (ce_phase == 0);
                end
                default: ClkEnable = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpv);
        bus.Value = v; bus.DigitEn = en; bus.DpIn = dpv; bus.Load = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge Clk);
            n++;
            if (bus.LoadAck) seen = 1'b1;
        end
        check({tag, "_ack_seen"}, 32'(seen), 1);
    endtask

    task automatic wait_fd(input string tag, input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge Clk);
            n++;
            if (FrameDone) seen = 1'b1;
        end
        check({tag, "_fd_seen"}, 32'(seen), 1);
    endtask

    // Called right after the LoadAck cycle, with ClkEnable high every clock.
    // segs/dps are packed {digit3..digit0}; dps are the active-low dp levels.
    task automatic check_slots(input string tag, input logic [27:0] segs, input logic [3:0] dps);
        logic [15:0] ans = 16'h7BDE;
        for (int k = 1; k <= 17; k++) begin
            @(negedge Clk);
            check({tag, "_no_ack"}, 32'(bus.LoadAck), 0);
            if (k == 1) check({tag, "_blank_tick"}, 32'(an), 32'hF);
            for (int d = 0; d < 4; d++) begin
                if (k == 4*d + 2) begin
                    check({tag, "_an"},  32'(an),  32'(ans[4*d +: 4]));
                    check({tag, "_seg"}, 32'(seg), 32'(segs[7*d +: 7]));
                    check({tag, "_dp"},  32'(dp),  32'(dps[d]));
                end
            end
        end
    endtask

    int  first_fd, last_fd, fd_cnt, gap_bad, ack_cnt, an_lit;
    int  run_len, runs_checked, an_illegal;
    bit  first_run, seen_b;
    logic [3:0] prev_an;

    initial begin
        bus.Value = '0; bus.DigitEn = '0; bus.DpIn = '0; bus.Load = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_an",  32'(an),          32'hF);
        check("rst_seg", 32'(seg),         32'h7F);
        check("rst_dp",  32'(dp),          1);
        check("rst_ack", 32'(bus.LoadAck), 0);
        check("rst_fd",  32'(FrameDone),   0);
        Rst = 1'b0;
        cmp_en = 1'b1;

        // Idle: display stays blank, FrameDone every 16 clocks, no LoadAck.
        fd_cnt = 0; ack_cnt = 0; an_lit = 0; first_fd = 0; last_fd = 0; gap_bad = 0;
        for (int k = 1; k <= 56; k++) begin
            @(negedge Clk);
            if (FrameDone) begin
                if (fd_cnt == 0) first_fd = k;
                else if (k - last_fd != 16) gap_bad++;
                last_fd = k;
                fd_cnt++;
            end
            if (bus.LoadAck) ack_cnt++;
            if (an != 4'hF) an_lit++;
        end
        check("idle_first_fd", first_fd, 16);
        check("idle_fd_count", fd_cnt, 3);
        check("idle_fd_gap",   gap_bad, 0);
        check("idle_ack",      ack_cnt, 0);
        check("idle_an_lit",   an_lit, 0);

        // Mid-frame load of 1234.
        do_load(16'h1234, 4'hF, 4'b0010);
        wait_ack("s1234", 40);
        check_slots("s1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1101);

        // Two loads in one frame: only the last is shown, one LoadAck.
        do_load(16'hAAAA, 4'hF, 4'h0);
        repeat (3) @(negedge Clk);
        do_load(16'hBEEF, 4'hF, 4'h0);
        wait_ack("sbeef", 40);
        check_slots("sbeef", {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}, 4'b1111);

        // Load exactly in the boundary cycle.
        wait_fd("s00c0", 40);
        repeat (15) @(negedge Clk);
        do_load(16'h00C0, 4'hF, 4'h0);
        check("s00c0_ack_bypass", 32'(bus.LoadAck), 1);
        check_slots("s00c0", {7'b1000000, 7'b1000000, 7'b1000110, 7'b1000000}, 4'b1111);

        // Sparse ticks with digits 0 and 2 enabled.
        ce_mode = 2;
        do_load(16'h5A3C, 4'b0101, 4'($urandom));
        wait_ack("ssparse", 200);
        @(negedge Clk);
        prev_an = an; run_len = 1; first_run = 1'b1; runs_checked = 0; an_illegal = 0;
        for (int k = 0; k < 240; k++) begin
            @(negedge Clk);
            if (an != 4'hF && an != 4'hE && an != 4'hB) an_illegal++;
            if (an == prev_an) begin
                run_len++;
            end else begin
                if (!first_run) begin
                    check("ssparse_run", run_len, (prev_an == 4'hF) ? 25 : 15);
                    runs_checked++;
                end
                first_run = 1'b0;
                prev_an = an;
                run_len = 1;
            end
        end
        check("ssparse_an_legal", an_illegal, 0);
        check("ssparse_runs_enough", 32'(runs_checked >= 4), 1);

        // Randomised traffic against the model.
        ce_mode = 3;
        for (int k = 0; k < 700; k++) begin
            if (k == 350) ce_mode = 1;
            bus.Value   = 16'($urandom);
            bus.DigitEn = 4'($urandom);
            bus.DpIn    = 4'($urandom);
            bus.Load    = ($urandom_range(0, 5) == 0);
            @(negedge Clk);
        end
        bus.Load = 1'b0;

        // Asynchronous reset while digit 2 is lit and a load is pending.
        ce_mode = 1;
        repeat (2) @(negedge Clk);
        wait_fd("srst", 40);
        repeat (2) @(negedge Clk);
        do_load(16'h4321, 4'hF, 4'h0);
        wait_ack("srst", 40);
        do_load(16'hFFFF, 4'hF, 4'hF);
        seen_b = 1'b0;
        for (int k = 0; k < 40 && !seen_b; k++) begin
            if (an == 4'hB) seen_b = 1'b1;
            else @(negedge Clk);
        end
        check("srst_digit2_lit", 32'(seen_b), 1);
        #2 Rst = 1'b1;
        #1;
        check("srst_async_an",  32'(an),          32'hF);
        check("srst_async_seg", 32'(seg),         32'h7F);
        check("srst_async_dp",  32'(dp),          1);
        check("srst_async_ack", 32'(bus.LoadAck), 0);
        check("srst_async_fd",  32'(FrameDone),   0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        first_fd = 0; ack_cnt = 0; an_lit = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (FrameDone && first_fd == 0) first_fd = k;
            if (bus.LoadAck) ack_cnt++;
            if (an != 4'hF) an_lit++;
        end
        check("srst_first_fd", first_fd, 16);
        check("srst_no_ack",   ack_cnt, 0);
        check("srst_blank",    an_lit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
